// File: rtl/otter_intrpt_ctrl_if.sv
// Interrupt request handshake between the interrupt controller and the CU FSM.
// Controller raises vld/id; the CU answers with a one-cycle taken pulse.
interface otter_intrpt_ctrl_if #(
  parameter int NUM_SRC = 8,
  parameter int IDW     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
);
  logic           intrpt_vld;
  logic [IDW-1:0] intrpt_id;
  logic           intrpt_taken;

  modport master (
    output intrpt_vld,
    output intrpt_id,
    input  intrpt_taken
  );

  modport slave (
    input  intrpt_vld,
    input  intrpt_id,
    output intrpt_taken
  );
endinterface

// File: rtl/otter_intrpt_ctrl.sv
// Interrupt controller: sync + edge-detect sources into pending latches,
// mask, pick lowest index, and present one request at a time to the CU.
module otter_intrpt_ctrl #(
  parameter int NUM_SRC     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int GAP_CYCLES  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  output logic [NUM_SRC-1:0] mask,
  output logic [NUM_SRC-1:0] pending,
  otter_intrpt_ctrl_if.master irq_if
);

  localparam int IDW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GAP    = 2'd2
  } state_e;

  logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q;
  logic [NUM_SRC-1:0] hist_q;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] clr;
  logic [NUM_SRC-1:0] elig;
  logic [IDW-1:0]     win;

  state_e         state_q, state_d;
  logic           vld_q, vld_d;
  logic [IDW-1:0] id_q, id_d;
  logic [GW-1:0]  gap_q, gap_d;

  // Only the last sync stage is safe to use; history gives edges.
  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign elig = pend_q & ~mask_q;

  always_comb begin
    win = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig[i]) win = IDW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    vld_d   = vld_q;
    id_d    = id_q;
    gap_d   = gap_q;
    clr     = '0;
    unique case (state_q)
      IDLE: begin
        vld_d = 1'b0;
        if (|elig) begin
          id_d    = win;
          vld_d   = 1'b1;
          state_d = ASSERT;
        end
      end
      ASSERT: begin
        vld_d = 1'b1;
        if (irq_if.intrpt_taken) begin
          clr[id_q] = 1'b1;
          vld_d     = 1'b0;
          gap_d     = GW'(GAP_CYCLES - 1);
          state_d   = GAP;
        end
      end
      GAP: begin
        vld_d = 1'b0;
        if (gap_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: begin
        vld_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // A fresh edge on the same cycle as the clear keeps the bit set.
  assign pend_d = (pend_q & ~clr) | rise;
  assign mask_d = mask_we ? mask_wdata : mask_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      hist_q  <= '0;
      pend_q  <= '0;
      mask_q  <= '1;
      state_q <= IDLE;
      vld_q   <= 1'b0;
      id_q    <= '0;
      gap_q   <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], src_irq};
      hist_q  <= sync_q[SYNC_STAGES-1];
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      state_q <= state_d;
      vld_q   <= vld_d;
      id_q    <= id_d;
      gap_q   <= gap_d;
    end
  end

  assign mask              = mask_q;
  assign pending           = pend_q;
  assign irq_if.intrpt_vld = vld_q;
  assign irq_if.intrpt_id  = id_q;

endmodule

// File: tb/tb_otter_intrpt_ctrl.sv
// Bench for otter_intrpt_ctrl: directed scenarios plus random batches,
// expected service order queued at stimulus time and checked on each request.
module tb_otter_intrpt_ctrl;
  localparam int N   = 8;
  localparam int IDW = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] src_irq;
  logic         mask_we;
  logic [N-1:0] mask_wdata;
  logic [N-1:0] mask;
  logic [N-1:0] pending;
  logic         taken_dir;
  logic         taken_auto;
  bit           auto_cu;

  int checks = 0;
  int passed = 0;
  int unsigned sb[$];

  otter_intrpt_ctrl_if #(.NUM_SRC(N)) irq_if ();
  assign irq_if.intrpt_taken = taken_dir | taken_auto;

  otter_intrpt_ctrl #(
    .NUM_SRC(N),
    .SYNC_STAGES(2),
    .GAP_CYCLES(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .src_irq(src_irq),
    .mask_we(mask_we),
    .mask_wdata(mask_wdata),
    .mask(mask),
    .pending(pending),
    .irq_if(irq_if.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Monitor: every new request must match the next queued id.
  initial begin
    logic           pv;
    int             lo;
    bit             seen;
    logic [IDW-1:0] lid;
    int unsigned    e;
    pv = 1'b0; lo = 0; seen = 0; lid = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        pv = 1'b0; lo = 0; seen = 0;
      end else begin
        if (irq_if.intrpt_vld === 1'b1 && !pv) begin
          if (seen) chk("gap_low", 32'(lo >= 2), 1);
          chk("req_expected", 32'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("req_id", 32'(irq_if.intrpt_id), e);
          end
          lid = irq_if.intrpt_id; seen = 1; lo = 0;
        end else if (irq_if.intrpt_vld === 1'b1) begin
          chk("id_stable", 32'(irq_if.intrpt_id), 32'(lid));
        end else begin
          lo++;
        end
        pv = (irq_if.intrpt_vld === 1'b1);
      end
    end
  end

  // Behavioural CU: acknowledges a request after a random delay.
  initial begin
    int d;
    taken_auto = 1'b0;
    forever begin
      @(negedge clk);
      if (auto_cu && irq_if.intrpt_vld === 1'b1) begin
        d = $urandom_range(0, 3);
        repeat (d) @(negedge clk);
        taken_auto = 1'b1;
        @(negedge clk);
        taken_auto = 1'b0;
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wmask(input logic [N-1:0] v);
    mask_wdata = v; mask_we = 1'b1;
    step();
    mask_we = 1'b0;
  endtask

  task automatic take();
    taken_dir = 1'b1;
    step();
    taken_dir = 1'b0;
  endtask

  task automatic wait_idle(input int tgt, input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (sb.size() == tgt && irq_if.intrpt_vld === 1'b0) begin
        ok = 1;
        break;
      end
      step();
    end
    chk({nm, "_done"}, 32'(ok), 1);
  endtask

  task automatic vld_is(input string nm, input logic v, input int id);
    chk({nm, "_vld"}, 32'(irq_if.intrpt_vld), 32'(v));
    if (v) chk({nm, "_id"}, 32'(irq_if.intrpt_id), id);
  endtask

  initial begin
    logic [N-1:0] m, s;
    int nm;
    rst = 1'b1; src_irq = '0; mask_we = 1'b0; mask_wdata = '0;
    taken_dir = 1'b0; auto_cu = 0;
    step(3);
    chk("rst_mask", 32'(mask), 32'hff);
    chk("rst_pend", 32'(pending), 0);
    chk("rst_vld", 32'(irq_if.intrpt_vld), 0);
    chk("rst_id", 32'(irq_if.intrpt_id), 0);
    rst = 1'b0;
    step();

    // Single source latency and take.
    wmask('0);
    src_irq = 8'h08; sb.push_back(3);
    step(3);
    chk("t1_pend", 32'(pending), 32'h08);
    vld_is("t1_early", 1'b0, 0);
    step();
    vld_is("t1_req", 1'b1, 3);
    step();
    src_irq = '0;
    take();
    chk("t1_clr", 32'(pending), 0);
    vld_is("t1_after", 1'b0, 0);
    step(3);

    // Two simultaneous edges, lowest first, two-cycle gap.
    src_irq = 8'h24; sb.push_back(2); sb.push_back(5);
    step(4);
    vld_is("t2_first", 1'b1, 2);
    src_irq = '0;
    take();
    vld_is("t2_gap0", 1'b0, 0);
    step();
    vld_is("t2_gap1", 1'b0, 0);
    step();
    vld_is("t2_second", 1'b1, 5);
    take();
    chk("t2_clr", 32'(pending), 0);
    step(3);

    // Masked source latches but waits for unmask.
    wmask(8'h01);
    src_irq = 8'h01;
    step(3);
    chk("t3_pend", 32'(pending), 32'h01);
    src_irq = '0;
    step(3);
    vld_is("t3_masked", 1'b0, 0);
    sb.push_back(0);
    wmask('0);
    vld_is("t3_wr_edge", 1'b0, 0);
    step();
    vld_is("t3_req", 1'b1, 0);
    take();
    step(3);

    // Masking during ASSERT does not withdraw.
    src_irq = 8'h10; sb.push_back(4);
    step(4);
    vld_is("t4_req", 1'b1, 4);
    src_irq = '0;
    wmask(8'h10);
    vld_is("t4_hold0", 1'b1, 4);
    step(2);
    vld_is("t4_hold1", 1'b1, 4);
    take();
    chk("t4_pend4", 32'(pending[4]), 0);
    vld_is("t4_after", 1'b0, 0);
    wmask('0);
    step(3);

    // New edge on the take edge: set wins, re-request after gap.
    src_irq = 8'h02; sb.push_back(1);
    step(4);
    vld_is("t5_req", 1'b1, 1);
    src_irq = '0;
    step(2);
    src_irq = 8'h02;
    step(2);
    sb.push_back(1);
    take();
    chk("t5_set_wins", 32'(pending), 32'h02);
    vld_is("t5_gap0", 1'b0, 0);
    step();
    vld_is("t5_gap1", 1'b0, 0);
    step();
    vld_is("t5_rereq", 1'b1, 1);
    take();
    chk("t5_held_high", 32'(pending), 0);
    src_irq = '0;
    step(3);

    // Taken while IDLE is ignored.
    wmask(8'h80);
    src_irq = 8'h80;
    step(4);
    src_irq = '0;
    chk("idle_pend", 32'(pending), 32'h80);
    take();
    chk("idle_taken", 32'(pending), 32'h80);
    vld_is("idle_vld", 1'b0, 0);
    sb.push_back(7);
    wmask('0);
    step();
    vld_is("idle_unmask", 1'b1, 7);
    take();
    step(3);

    // Reset in ASSERT drops everything.
    src_irq = 8'h06; sb.push_back(1);
    step(4);
    vld_is("t6_req", 1'b1, 1);
    chk("t6_pend", 32'(pending), 32'h06);
    rst = 1'b1;
    step();
    vld_is("t6_rst", 1'b0, 0);
    chk("t6_rst_pend", 32'(pending), 0);
    chk("t6_rst_mask", 32'(mask), 32'hff);
    src_irq = '0;
    step(3);
    rst = 1'b0;
    step(5);
    chk("t6_quiet", 32'(pending), 0);
    chk("t6_sb_empty", 32'(sb.size()), 0);

    // Random batches: unmasked served ascending, then masked ones.
    auto_cu = 1;
    for (int r = 0; r < 40; r++) begin
      m = N'($urandom);
      s = N'($urandom_range(1, 255));
      wmask(m);
      nm = 0;
      for (int i = 0; i < N; i++)
        if (s[i] && !m[i]) sb.push_back(i);
      for (int i = 0; i < N; i++)
        if (s[i] && m[i]) begin
          sb.push_back(i);
          nm++;
        end
      src_irq = s;
      step($urandom_range(1, 4));
      src_irq = '0;
      wait_idle(nm, "rnd_unmasked");
      step(6);
      chk("rnd_masked_pend", 32'(pending), 32'(s & m));
      wmask('0);
      wait_idle(0, "rnd_masked");
      step(4);
      chk("rnd_clear", 32'(pending), 0);
    end
    auto_cu = 0;
    step(5);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
